mcpu_ctrl: RTL and testbench



---
 rtl/mcpu_ctrl_if.sv | 40 ++++
 rtl/mcpu_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mcpu_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_ctrl_if.sv
// Control/datapath bundle between the multi-cycle MIPS control unit
// and MDPath: IR + memory ready in, every enable/select/debug out.
interface mcpu_ctrl_if;
   logic [31:0] Inst_in;
   logic        MIO_ready;
   logic        MemRead;
   logic        MemWrite;
   logic        CPU_MIO;
   logic        IorD;
   logic        IRWrite;
   logic        PCWrite;
   logic        PCWriteCond;
   logic        Beq;
   logic [1:0]  PCSource;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic        ImmZext;
   logic [2:0]  ALU_Control;
   logic        RegWrite;
   logic [1:0]  RegDst;
   logic [1:0]  MemtoReg;
   logic        illegal;
   logic [3:0]  state_out;

   modport master (
      input  Inst_in, MIO_ready,
      output MemRead, MemWrite, CPU_MIO, IorD, IRWrite,
             PCWrite, PCWriteCond, Beq, PCSource,
             ALUSrcA, ALUSrcB, ImmZext, ALU_Control,
             RegWrite, RegDst, MemtoReg, illegal, state_out
   );

   modport slave (
      output Inst_in, MIO_ready,
      input  MemRead, MemWrite, CPU_MIO, IorD, IRWrite,
             PCWrite, PCWriteCond, Beq, PCSource,
             ALUSrcA, ALUSrcB, ImmZext, ALU_Control,
             RegWrite, RegDst, MemtoReg, illegal, state_out
   );
endinterface

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB and drives
// MDPath. Ports: clk, rst_n (async, active-low), bus (master modport).
module mcpu_ctrl (
   input  logic             clk,
   input  logic             rst_n,
   mcpu_ctrl_if.master      bus
);

   typedef enum logic [3:0] {
      S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MR  = 4'd3,
      S_LWB = 4'd4,  S_MW  = 4'd5,  S_RX  = 4'd6,  S_RWB = 4'd7,
      S_BR  = 4'd8,  S_J   = 4'd9,  S_IX  = 4'd10, S_IWB = 4'd11,
      S_JAL = 4'd12, S_JR  = 4'd13, S_ERR = 4'd14
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [5:0] w_op;
   logic [5:0] w_fn;
   logic [2:0] w_r_alu;
   logic       w_r_ok;
   logic [2:0] w_i_alu;
   logic       w_i_zext;
   logic       w_unused;

   assign w_op     = bus.Inst_in[31:26];
   assign w_fn     = bus.Inst_in[5:0];
   assign w_unused = ^bus.Inst_in[25:6];

   // R-type funct -> ALU op; w_r_ok low means an unsupported funct
   always_comb begin
      w_r_alu = 3'b010;
      w_r_ok  = 1'b1;
      case (w_fn)
         6'h20:   w_r_alu = 3'b010;
         6'h22:   w_r_alu = 3'b110;
         6'h24:   w_r_alu = 3'b000;
         6'h25:   w_r_alu = 3'b001;
         6'h26:   w_r_alu = 3'b011;
         6'h27:   w_r_alu = 3'b100;
         6'h2A:   w_r_alu = 3'b111;
         default: w_r_ok  = 1'b0;
      endcase
   end

   // Immediate ALU op, shared by IX and IWB so the result stays stable
   always_comb begin
      w_i_alu  = 3'b010;
      w_i_zext = 1'b0;
      case (w_op)
         6'h0A: w_i_alu = 3'b111;
         6'h0C: begin w_i_alu = 3'b000; w_i_zext = 1'b1; end
         6'h0D: begin w_i_alu = 3'b001; w_i_zext = 1'b1; end
         6'h0E: begin w_i_alu = 3'b011; w_i_zext = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IF;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next          = S_IF;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.CPU_MIO     = 1'b0;
      bus.IorD        = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.Beq         = 1'b0;
      bus.PCSource    = 2'b00;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.ImmZext     = 1'b0;
      bus.ALU_Control = 3'b010;
      bus.RegWrite    = 1'b0;
      bus.RegDst      = 2'b00;
      bus.MemtoReg    = 2'b00;
      bus.illegal     = 1'b0;
      case (r_state)
         S_IF: begin
            bus.MemRead = 1'b1;
            bus.CPU_MIO = 1'b1;
            bus.ALUSrcB = 2'b01;
            // IR and PC+4 commit only in the cycle memory delivers
            bus.IRWrite = bus.MIO_ready;
            bus.PCWrite = bus.MIO_ready;
            w_next      = bus.MIO_ready ? S_ID : S_IF;
         end
         S_ID: begin
            // Precompute branch target into ALUOut
            bus.ALUSrcB = 2'b11;
            case (w_op)
               6'h23, 6'h2B: w_next = S_MA;
               6'h00:        w_next = (w_fn == 6'h08) ? S_JR : S_RX;
               6'h04, 6'h05: w_next = S_BR;
               6'h02:        w_next = S_J;
               6'h03:        w_next = S_JAL;
               6'h08, 6'h0A, 6'h0C,
               6'h0D, 6'h0E, 6'h0F: w_next = S_IX;
               default:      w_next = S_ERR;
            endcase
         end
         S_MA: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            w_next      = (w_op == 6'h23) ? S_MR : S_MW;
         end
         S_MR: begin
            bus.MemRead = 1'b1;
            bus.CPU_MIO = 1'b1;
            bus.IorD    = 1'b1;
            w_next      = bus.MIO_ready ? S_LWB : S_MR;
         end
         S_LWB: begin
            bus.RegWrite = 1'b1;
            bus.MemtoReg = 2'b01;
         end
         S_MW: begin
            bus.MemWrite = 1'b1;
            bus.CPU_MIO  = 1'b1;
            bus.IorD     = 1'b1;
            w_next       = bus.MIO_ready ? S_IF : S_MW;
         end
         S_RX: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALU_Control = w_r_alu;
            w_next          = w_r_ok ? S_RWB : S_ERR;
         end
         S_RWB: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = 2'b01;
         end
         S_BR: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALU_Control = 3'b110;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = 2'b01;
            bus.Beq         = (w_op == 6'h04);
         end
         S_J: begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'b10;
         end
         S_JAL: begin
            // PC already holds the return address (fetch added 4)
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'b10;
            bus.RegWrite = 1'b1;
            bus.RegDst   = 2'b10;
            bus.MemtoReg = 2'b11;
         end
         S_JR: begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'b11;
         end
         S_IX: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUSrcB     = 2'b10;
            bus.ALU_Control = w_i_alu;
            bus.ImmZext     = w_i_zext;
            w_next          = S_IWB;
         end
         S_IWB: begin
            bus.RegWrite    = 1'b1;
            bus.MemtoReg    = (w_op == 6'h0F) ? 2'b10 : 2'b00;
            bus.ALU_Control = w_i_alu;
            bus.ImmZext     = w_i_zext;
         end
         S_ERR: begin
            bus.illegal = 1'b1;
         end
         default: w_next = S_IF;
      endcase
   end

   assign bus.state_out = r_state;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Scoreboard bench for mcpu_ctrl: per-instruction cycle paths are
// derived from instruction class and queued; a monitor checks each cycle.
module tb_mcpu_ctrl;

   typedef struct packed {
      logic       mr, mw, mio, iord, irw, pcw, pcwc, beq;
      logic [1:0] pcsrc;
      logic       srca;
      logic [1:0] srcb;
      logic       zext;
      logic [2:0] alu;
      logic       rw;
      logic [1:0] rdst;
      logic [1:0] m2r;
      logic       ill;
   } ctl_t;

   typedef struct {
      logic [31:0] inst;
      logic        rdy;
      logic [3:0]  st;
      ctl_t        ctl;
   } rec_t;

   logic clk;
   logic rst_n;
   mcpu_ctrl_if bus ();

   mcpu_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   rec_t pend[$];
   rec_t sb[$];
   ctl_t w_ctl;

   assign w_ctl = {bus.MemRead, bus.MemWrite, bus.CPU_MIO, bus.IorD,
                   bus.IRWrite, bus.PCWrite, bus.PCWriteCond, bus.Beq,
                   bus.PCSource, bus.ALUSrcA, bus.ALUSrcB, bus.ImmZext,
                   bus.ALU_Control, bus.RegWrite, bus.RegDst,
                   bus.MemtoReg, bus.illegal};

   // Expected control word for one cycle, from the per-state output table
   function automatic ctl_t exp_ctl(int st, logic [31:0] ir, logic rdy);
      ctl_t c;
      logic [5:0] op;
      logic [5:0] fn;
      op = ir[31:26];
      fn = ir[5:0];
      c = '0;
      c.alu = 3'b010;
      case (st)
         0: begin
            c.mr = 1; c.mio = 1; c.srcb = 2'b01;
            c.irw = rdy; c.pcw = rdy;
         end
         1: c.srcb = 2'b11;
         2: begin c.srca = 1; c.srcb = 2'b10; end
         3: begin c.mr = 1; c.mio = 1; c.iord = 1; end
         4: begin c.rw = 1; c.m2r = 2'b01; end
         5: begin c.mw = 1; c.mio = 1; c.iord = 1; end
         6: begin
            c.srca = 1;
            if (fn == 6'h20) c.alu = 3'b010;
            if (fn == 6'h22) c.alu = 3'b110;
            if (fn == 6'h24) c.alu = 3'b000;
            if (fn == 6'h25) c.alu = 3'b001;
            if (fn == 6'h26) c.alu = 3'b011;
            if (fn == 6'h27) c.alu = 3'b100;
            if (fn == 6'h2A) c.alu = 3'b111;
         end
         7: begin c.rw = 1; c.rdst = 2'b01; end
         8: begin
            c.srca = 1; c.alu = 3'b110; c.pcwc = 1;
            c.pcsrc = 2'b01; c.beq = (op == 6'h04);
         end
         9: begin c.pcw = 1; c.pcsrc = 2'b10; end
         12: begin
            c.pcw = 1; c.pcsrc = 2'b10; c.rw = 1;
            c.rdst = 2'b10; c.m2r = 2'b11;
         end
         13: begin c.pcw = 1; c.pcsrc = 2'b11; end
         10, 11: begin
            if (st == 10) begin c.srca = 1; c.srcb = 2'b10; end
            else begin
               c.rw = 1;
               c.m2r = (op == 6'h0F) ? 2'b10 : 2'b00;
            end
            if (op == 6'h0A) c.alu = 3'b111;
            if (op == 6'h0C) begin c.alu = 3'b000; c.zext = 1; end
            if (op == 6'h0D) begin c.alu = 3'b001; c.zext = 1; end
            if (op == 6'h0E) begin c.alu = 3'b011; c.zext = 1; end
         end
         14: c.ill = 1;
         default: ;
      endcase
      return c;
   endfunction

   task automatic add(int st, logic [31:0] ir, logic rdy);
      rec_t r;
      // IR content during fetch is stale; drive junk to prove it is ignored
      r.inst = (st == 0) ? $urandom : ir;
      r.rdy  = rdy;
      r.st   = st[3:0];
      r.ctl  = exp_ctl(st, ir, rdy);
      pend.push_back(r);
   endtask

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   // Cycle path of one instruction: fetch waits, decode, then by class
   task automatic build(logic [31:0] ir, int wif, int wm);
      logic [5:0] op;
      logic [5:0] fn;
      op = ir[31:26];
      fn = ir[5:0];
      for (int i = 0; i < wif; i++) add(0, ir, 1'b0);
      add(0, ir, 1'b1);
      add(1, ir, rnd1());
      if (op == 6'h23 || op == 6'h2B) begin
         add(2, ir, rnd1());
         for (int i = 0; i < wm; i++) add(op == 6'h23 ? 3 : 5, ir, 1'b0);
         add(op == 6'h23 ? 3 : 5, ir, 1'b1);
         if (op == 6'h23) add(4, ir, rnd1());
      end else if (op == 6'h00) begin
         if (fn == 6'h08) add(13, ir, rnd1());
         else begin
            add(6, ir, rnd1());
            if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A})
               add(7, ir, rnd1());
            else
               add(14, ir, rnd1());
         end
      end else if (op == 6'h04 || op == 6'h05) add(8, ir, rnd1());
      else if (op == 6'h02) add(9, ir, rnd1());
      else if (op == 6'h03) add(12, ir, rnd1());
      else if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) begin
         add(10, ir, rnd1());
         add(11, ir, rnd1());
      end else add(14, ir, rnd1());
   endtask

   task automatic play(bit rel, int lim);
      int n;
      n = 0;
      while (pend.size() > 0 && n < lim) begin
         rec_t r;
         r = pend.pop_front();
         @(posedge clk);
         #1;
         if (rel && n == 0) rst_n = 1'b1;
         bus.Inst_in   = r.inst;
         bus.MIO_ready = r.rdy;
         sb.push_back(r);
         n++;
      end
      pend.delete();
   endtask

   task automatic run(logic [31:0] ir, int wif, int wm, bit rel);
      build(ir, wif, wm);
      play(rel, 1000);
   endtask

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (sb.size() > 0) begin
         rec_t r;
         r = sb.pop_front();
         n_chk++;
         if (bus.state_out !== r.st) begin
            n_fail++;
            $display("FAIL state cyc=%0d inst=%h got=%0d exp=%0d",
                     cyc, r.inst, bus.state_out, r.st);
         end
         n_chk++;
         if (w_ctl !== r.ctl) begin
            n_fail++;
            $display("FAIL ctl st=%0d cyc=%0d inst=%h got=%h exp=%h",
                     r.st, cyc, r.inst, w_ctl, r.ctl);
         end
      end
   end

   function automatic logic [31:0] rnd_inst();
      logic [5:0] ops[14];
      logic [5:0] fns[9];
      logic [31:0] ir;
      ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h00};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
              6'h08, 6'h00};
      ir = $urandom;
      if ($urandom_range(0, 7) != 0) begin
         ir[31:26] = ops[$urandom_range(0, 13)];
         if (ir[31:26] == 6'h00 && $urandom_range(0, 5) != 0)
            ir[5:0] = fns[$urandom_range(0, 7)];
      end
      return ir;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n         = 1'b0;
      bus.Inst_in   = 32'h0;
      bus.MIO_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(bus.state_out), 32'd0);
      chk("rst_irwrite", 32'(bus.IRWrite), 32'd1);
      chk("rst_pcwrite", 32'(bus.PCWrite), 32'd1);
      bus.MIO_ready = 1'b0;
      #1;
      chk("rst_irwrite_lo", 32'(bus.IRWrite), 32'd0);

      run(32'h00221820, 0, 0, 1'b1);
      run(32'h8C430004, 0, 2, 1'b0);
      run(32'h10220003, 0, 0, 1'b0);
      run(32'h14220003, 0, 0, 1'b0);
      run(32'h0C000010, 0, 0, 1'b0);
      run(32'h03E00008, 0, 0, 1'b0);
      run(32'h34220F0F, 0, 0, 1'b0);
      run(32'h3C011234, 0, 0, 1'b0);
      run(32'hFC000000, 0, 0, 1'b0);
      run(32'hAC430008, 1, 2, 1'b0);
      run(32'h0022183F, 0, 0, 1'b0);

      // Abort a load while it waits in MR
      build(32'h8C430004, 0, 2);
      play(1'b0, 4);
      @(posedge clk);
      #1;
      rst_n         = 1'b0;
      bus.MIO_ready = 1'b0;
      #1;
      chk("abort_state", 32'(bus.state_out), 32'd0);
      chk("abort_memread", 32'(bus.MemRead), 32'd1);
      chk("abort_iord", 32'(bus.IorD), 32'd0);
      @(posedge clk);
      run(32'h00221822, 0, 0, 1'b1);

      for (int k = 0; k < 200; k++)
         run(rnd_inst(), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain left=%0d exp=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
